dot_product_seq_ctrl: RTL and testbench

- Sequencer for the signed dot-product datapath.
- Accepts a job (vector length) over a valid/ready handshake and streams element addresses to a shared dual-operand memory with 1-cycle read latency.
- Multiply-accumulates the returned element pairs and presents the final sum over a valid/ready result handshake.
- Sits between the job-issuing control logic and the operand memory feeding the dot-product datapath.

---
 rtl/dot_product_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_dot_product_seq_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_seq_ctrl.sv
// dot_product_seq_ctrl
//   Sequencer for the signed dot-product datapath. Accepts a job (vector
//   length) over a valid/ready handshake, streams element addresses to a
//   dual-operand memory with 1-cycle read latency, multiply-accumulates the
//   returned pairs and presents the sum over a valid/ready result handshake.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   start_valid  job request
//   start_ready  job can be accepted (IDLE only)
//   len          job length in elements, clamped to N, sampled on start
//   mem_rd_en    operand read strobe
//   mem_addr     element index being read (registered, holds when idle)
//   mem_rdata_a  signed operand A, valid the cycle after mem_rd_en
//   mem_rdata_b  signed operand B, valid the cycle after mem_rd_en
//   res_valid    result available (DONE)
//   res_ready    consumer accepts result
//   result       signed dot product
//   busy         high in RUN, DRAIN and DONE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a job; start_ready high
// RUN   | one read per cycle, addr 0 .. eff_len-1
// DRAIN | no read; last returned product is accumulated
// DONE  | result presented and held until res_ready

module dot_product_seq_ctrl #(
    parameter int N  = 8,
    parameter int DW = 8,
    parameter int AW = $clog2(N),
    parameter int LW = $clog2(N + 1),
    parameter int RW = 2 * DW + $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [LW-1:0]        len,
    output logic                 mem_rd_en,
    output logic [AW-1:0]        mem_addr,
    input  logic [DW-1:0]        mem_rdata_a,
    input  logic [DW-1:0]        mem_rdata_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic signed [RW-1:0] result,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [LW-1:0]          eff_len;
    logic [LW-1:0]          rem;        // reads still to issue after the current one
    logic                   rd_q;       // read issued last cycle -> data valid now
    logic                   start_fire;
    logic signed [DW-1:0]   op_a;
    logic signed [DW-1:0]   op_b;
    logic signed [2*DW-1:0] prod;
    logic signed [RW-1:0]   prod_ext;
    logic signed [RW-1:0]   acc;

    assign start_fire = start_valid && start_ready;
    assign eff_len    = (len > LW'(N)) ? LW'(N) : len;

    assign op_a     = mem_rdata_a;
    assign op_b     = mem_rdata_b;
    assign prod     = op_a * op_b;
    assign prod_ext = {{(RW - 2 * DW){prod[2*DW-1]}}, prod};

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_fire) begin
                    state_nxt = (eff_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (rem == '0) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // outputs
    always_comb begin
        start_ready = 1'b0;
        mem_rd_en   = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b1;
        case (state)
            S_IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
            end
            S_RUN: begin
                mem_rd_en = 1'b1;
            end
            S_DONE: begin
                res_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // address down-counter and accumulator
    always_ff @(posedge clk) begin
        if (reset) begin
            rem      <= '0;
            mem_addr <= '0;
            rd_q     <= 1'b0;
            acc      <= '0;
        end else begin
            rd_q <= mem_rd_en;

            if (state == S_IDLE && start_fire) begin
                acc <= '0;
                // A zero-length job issues no reads, so the address is left alone.
                if (eff_len != '0) begin
                    rem      <= eff_len - LW'(1);
                    mem_addr <= '0;
                end
            end else if (rd_q) begin
                acc <= acc + prod_ext;
            end

            if (state == S_RUN && rem != '0) begin
                rem      <= rem - LW'(1);
                mem_addr <= mem_addr + AW'(1);
            end
        end
    end

    assign result = acc;

endmodule

// File: tb/tb_dot_product_seq_ctrl.sv
// Testbench for dot_product_seq_ctrl: directed and randomized jobs checked
// against a behavioural sum-of-products model and the cycle timeline
// (reads in cycles 1..eff_len, result in cycle eff_len+2, or 1 for len 0).

module tb_dot_product_seq_ctrl;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int AW = $clog2(N);
    localparam int LW = $clog2(N + 1);
    localparam int RW = 2 * DW + $clog2(N + 1);

    logic                 tb_clk;
    logic                 reset;
    logic                 start_valid;
    logic                 start_ready;
    logic [LW-1:0]        len;
    logic                 mem_rd_en;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_rdata_a;
    logic [DW-1:0]        mem_rdata_b;
    logic                 res_valid;
    logic                 res_ready;
    logic signed [RW-1:0] result;
    logic                 busy;

    int mem_a [N];
    int mem_b [N];
    int checks;
    int errors;

    dot_product_seq_ctrl #(.N(N), .DW(DW)) dut (
        .clk         (tb_clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .len         (len),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata_a (mem_rdata_a),
        .mem_rdata_b (mem_rdata_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .busy        (busy)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Memory with 1-cycle read latency; drives random garbage when no read
    // was issued in the previous cycle.
    initial begin
        int rd_p;
        int addr_p;
        rd_p        = 0;
        addr_p      = 0;
        mem_rdata_a = '0;
        mem_rdata_b = '0;
        forever begin
            @(negedge tb_clk);
            if (rd_p != 0) begin
                mem_rdata_a = DW'(mem_a[addr_p]);
                mem_rdata_b = DW'(mem_b[addr_p]);
            end else begin
                mem_rdata_a = DW'($urandom);
                mem_rdata_b = DW'($urandom);
            end
            rd_p   = int'(mem_rd_en);
            addr_p = int'(mem_addr);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            mem_a[i] = int'($urandom_range(0, 255)) - 128;
            mem_b[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic fill_const(input int va, input int vb);
        for (int i = 0; i < N; i++) begin
            mem_a[i] = va;
            mem_b[i] = vb;
        end
    endtask

    // Runs one job of length ln, holding res_ready low for hold cycles once
    // the result is up. Stray start_valid/res_ready pulses must be ignored.
    task automatic run_job(input int ln, input int hold);
        int eff;
        int exp_sum;
        int done_k;
        eff     = (ln > N) ? N : ln;
        exp_sum = 0;
        for (int i = 0; i < eff; i++) exp_sum += mem_a[i] * mem_b[i];
        done_k = (eff == 0) ? 1 : eff + 2;

        @(negedge tb_clk);
        check("idle_start_ready", int'(start_ready), 1);
        start_valid = 1'b1;
        len         = LW'(ln);
        res_ready   = 1'($urandom);

        for (int k = 1; k <= done_k; k++) begin
            @(negedge tb_clk);
            check("rd_en", int'(mem_rd_en), (k <= eff) ? 1 : 0);
            if (k <= eff) check("addr", int'(mem_addr), k - 1);
            check("res_valid", int'(res_valid), (k == done_k) ? 1 : 0);
            check("busy", int'(busy), 1);
            check("start_ready_busy", int'(start_ready), 0);
            if (k == done_k) begin
                check("result", int'(result), exp_sum);
                if (eff > 0) check("addr_hold", int'(mem_addr), eff - 1);
                res_ready   = (hold == 0);
                start_valid = (hold == 0) ? 1'b0 : 1'($urandom);
            end else begin
                res_ready   = 1'($urandom);
                start_valid = 1'($urandom);
            end
        end

        for (int h = 1; h <= hold; h++) begin
            @(negedge tb_clk);
            check("hold_valid", int'(res_valid), 1);
            check("hold_result", int'(result), exp_sum);
            check("hold_start_ready", int'(start_ready), 0);
            check("hold_rd_en", int'(mem_rd_en), 0);
            res_ready   = (h == hold);
            start_valid = (h == hold) ? 1'b0 : 1'($urandom);
        end

        @(negedge tb_clk);
        check("post_valid", int'(res_valid), 0);
        check("post_start_ready", int'(start_ready), 1);
        check("post_busy", int'(busy), 0);
        check("post_rd_en", int'(mem_rd_en), 0);
        res_ready = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        start_valid = 1'b0;
        len         = '0;
        res_ready   = 1'b0;
        fill_const(0, 0);

        repeat (3) @(negedge tb_clk);
        check("rst_start_ready", int'(start_ready), 1);
        check("rst_rd_en", int'(mem_rd_en), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_valid", int'(res_valid), 0);
        check("rst_result", int'(result), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;

        // basic job, 1..4 squared = 30
        fill_random();
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = i + 1;
            mem_b[i] = i + 1;
        end
        run_job(4, 0);

        // signed operands: -3 + -8 = -11
        fill_random();
        mem_a[0] = -1; mem_a[1] = 2;
        mem_b[0] = 3;  mem_b[1] = -4;
        run_job(2, 1);

        // extreme values: 8 * 16384 = 131072
        fill_const(-128, -128);
        run_job(8, 0);

        // zero length
        fill_random();
        run_job(0, 0);

        // backpressure with start_valid pulses
        fill_random();
        run_job(3, 5);

        // reset mid-RUN
        fill_random();
        @(negedge tb_clk);
        start_valid = 1'b1;
        len         = LW'(6);
        @(negedge tb_clk);
        start_valid = 1'b0;
        @(negedge tb_clk);
        check("abort_pre_rd_en", int'(mem_rd_en), 1);
        check("abort_pre_addr", int'(mem_addr), 1);
        reset = 1'b1;
        @(negedge tb_clk);
        reset = 1'b0;
        check("abort_rd_en", int'(mem_rd_en), 0);
        check("abort_valid", int'(res_valid), 0);
        check("abort_start_ready", int'(start_ready), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_result", int'(result), 0);
        fill_random();
        mem_a[0] = 5;
        mem_b[0] = 7;
        run_job(1, 0);

        // clamping: len 12 -> 8 reads of ones
        fill_const(1, 1);
        run_job(12, 0);

        // randomized jobs
        for (int j = 0; j < 25; j++) begin
            fill_random();
            run_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
